// File: rtl/pit_bus_sequencer.sv
// pit_bus_sequencer: 8254-style bus decode, control/count write sequencing and read-data mux.
// Build with READBACK_EN defined to enable the SC=3 read-back command.
module pit_bus_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RW_RESET    = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CS,
  input  logic        RD,
  input  logic        WR,
  input  logic [1:0]  A,
  input  logic [7:0]  din,
  input  logic [15:0] ol0,
  input  logic [15:0] ol1,
  input  logic [15:0] ol2,
  input  logic [7:0]  status0,
  input  logic [7:0]  status1,
  input  logic [7:0]  status2,
  output logic [7:0]  dout,
  output logic        dout_oe,
  output logic [2:0]  cw_wr,
  output logic [7:0]  cw_data,
  output logic [2:0]  cr_lsb_wr,
  output logic [2:0]  cr_msb_wr,
  output logic [7:0]  cr_data,
  output logic [2:0]  count_loaded,
  output logic [2:0]  latch_cmd,
  output logic [2:0]  status_latch
);
  logic [SYNC_STAGES-1:0] rd_sr, wr_sr;
  logic rd_s, wr_s, rd_d, wr_d, rd_rise, wr_rise, wcs, rcs;
  logic [1:0] wa, ra, ci;
  logic [7:0] wd, st, sel;
  logic [15:0] ol;
  logic [2:0][1:0] rw;
  logic [2:0] wtog, rtog, lpend, spend;
  assign rd_s = rd_sr[SYNC_STAGES-1];
  assign wr_s = wr_sr[SYNC_STAGES-1];
  assign rd_rise = rd_s & ~rd_d;
  assign wr_rise = wr_s & ~wr_d;
  assign dout_oe = ~rd_s & wr_s & ~CS & (A != 2'd3);
  always_comb begin
    ci = (A == 2'd3) ? 2'd0 : A;
    ol = (ci == 2'd0) ? ol0 : (ci == 2'd1) ? ol1 : ol2;
    st = (ci == 2'd0) ? status0 : (ci == 2'd1) ? status1 : status2;
    sel = spend[ci] ? st :
          (rw[ci] == 2'b01) ? ol[7:0] :
          (rw[ci] == 2'b10) ? ol[15:8] :
          (rw[ci] == 2'b11) ? (rtog[ci] ? ol[15:8] : ol[7:0]) : 8'h00;
    dout = dout_oe ? sel : 8'h00;
  end
  // Captures are forced to "deselected" whenever the other strobe is also low,
  // so an overlapping RD/WR cycle neither commits nor advances a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sr <= '1;
      wr_sr <= '1;
      rd_d <= 1'b1;
      wr_d <= 1'b1;
      wcs <= 1'b1;
      rcs <= 1'b1;
      wa <= '0;
      ra <= '0;
      wd <= '0;
      rw <= {3{RW_RESET}};
      wtog <= '0;
      rtog <= '0;
      lpend <= '0;
      spend <= '0;
      cw_wr <= '0;
      cw_data <= '0;
      cr_lsb_wr <= '0;
      cr_msb_wr <= '0;
      cr_data <= '0;
      count_loaded <= '0;
      latch_cmd <= '0;
      status_latch <= '0;
    end else begin
      rd_sr <= SYNC_STAGES'({rd_sr, RD});
      wr_sr <= SYNC_STAGES'({wr_sr, WR});
      rd_d <= rd_s;
      wr_d <= wr_s;
      if (!wr_s) begin
        wcs <= CS | ~rd_s;
        wa <= A;
        wd <= din;
      end
      if (!rd_s) begin
        rcs <= CS | ~wr_s;
        ra <= A;
      end
      cw_wr <= '0;
      cr_lsb_wr <= '0;
      cr_msb_wr <= '0;
      count_loaded <= '0;
      latch_cmd <= '0;
      status_latch <= '0;
      if (rd_rise && !rcs && ra != 2'd3) begin
        if (spend[ra]) spend[ra] <= 1'b0;
        else if (rw[ra] == 2'b11) begin
          rtog[ra] <= ~rtog[ra];
          if (rtog[ra]) lpend[ra] <= 1'b0;
        end else lpend[ra] <= 1'b0;
      end
      if (wr_rise && !wcs) begin
        if (wa == 2'd3) begin
          if (wd[7:6] != 2'd3) begin
            if (wd[5:4] != 2'b00) begin
              rw[wd[7:6]] <= wd[5:4];
              cw_wr[wd[7:6]] <= 1'b1;
              cw_data <= wd;
              wtog[wd[7:6]] <= 1'b0;
              rtog[wd[7:6]] <= 1'b0;
              lpend[wd[7:6]] <= 1'b0;
              spend[wd[7:6]] <= 1'b0;
            end else begin
              latch_cmd[wd[7:6]] <= ~lpend[wd[7:6]];
              lpend[wd[7:6]] <= 1'b1;
            end
          end
`ifdef READBACK_EN
          else begin
            for (int i = 0; i < 3; i++) begin
              if (wd[i+1]) begin
                if (!wd[5] && !lpend[i]) begin
                  latch_cmd[i] <= 1'b1;
                  lpend[i] <= 1'b1;
                end
                if (!wd[4] && !spend[i]) begin
                  status_latch[i] <= 1'b1;
                  spend[i] <= 1'b1;
                end
              end
            end
          end
`endif
        end else begin
          cr_data <= wd;
          if (rw[wa] == 2'b01) begin
            cr_lsb_wr[wa] <= 1'b1;
            count_loaded[wa] <= 1'b1;
          end else if (rw[wa] == 2'b10) begin
            cr_msb_wr[wa] <= 1'b1;
            count_loaded[wa] <= 1'b1;
          end else if (rw[wa] == 2'b11) begin
            cr_lsb_wr[wa] <= ~wtog[wa];
            cr_msb_wr[wa] <= wtog[wa];
            count_loaded[wa] <= wtog[wa];
            wtog[wa] <= ~wtog[wa];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pit_bus_sequencer.sv
// tb_pit_bus_sequencer: directed bus cycles against pit_bus_sequencer with hand-computed results.
module tb_pit_bus_sequencer;
  logic clk = 0, rst = 1, CS = 1, RD = 1, WR = 1;
  logic [1:0] A = 0;
  logic [7:0] din = 0, status0 = 8'h36, status1 = 8'h45, status2 = 8'h54;
  logic [15:0] ol0 = 16'h1234, ol1 = 16'h5678, ol2 = 16'h9abc;
  logic [7:0] dout, cw_data, cr_data;
  logic dout_oe;
  logic [2:0] cw_wr, cr_lsb_wr, cr_msb_wr, count_loaded, latch_cmd, status_latch;
  logic [2:0] a_cw, a_lsb, a_msb, a_ld, a_lat, a_st;
  logic [7:0] a_cwd, a_crd, d;
  logic oe, any;
  int npul, lat, checks = 0, errors = 0;
  pit_bus_sequencer dut (
    .clk(clk), .rst(rst), .CS(CS), .RD(RD), .WR(WR), .A(A), .din(din),
    .ol0(ol0), .ol1(ol1), .ol2(ol2), .status0(status0), .status1(status1), .status2(status2),
    .dout(dout), .dout_oe(dout_oe), .cw_wr(cw_wr), .cw_data(cw_data),
    .cr_lsb_wr(cr_lsb_wr), .cr_msb_wr(cr_msb_wr), .cr_data(cr_data),
    .count_loaded(count_loaded), .latch_cmd(latch_cmd), .status_latch(status_latch)
  );
  always #5 clk = ~clk;
  assign any = |{cw_wr, cr_lsb_wr, cr_msb_wr, count_loaded, latch_cmd, status_latch};
  always @(negedge clk) if (any) begin
    a_cw |= cw_wr;
    a_lsb |= cr_lsb_wr;
    a_msb |= cr_msb_wr;
    a_ld |= count_loaded;
    a_lat |= latch_cmd;
    a_st |= status_latch;
    npul++;
    if (|cw_wr) a_cwd = cw_data;
    if (|{cr_lsb_wr, cr_msb_wr}) a_crd = cr_data;
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {a_cw, a_lsb, a_msb, a_ld, a_lat, a_st} = '0;
    a_cwd = 0;
    a_crd = 0;
    npul = 0;
  endtask
  task automatic bw(input logic [1:0] a, input logic [7:0] v);
    clr();
    @(posedge clk); #1;
    CS = 0; A = a; din = v; WR = 0;
    repeat (4) @(posedge clk);
    #1 WR = 1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (lat == 0 && any) lat = k;
    end
    CS = 1;
  endtask
  task automatic br(input logic [1:0] a);
    @(posedge clk); #1;
    CS = 0; A = a; RD = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    d = dout;
    oe = dout_oe;
    @(posedge clk); #1 RD = 1;
    repeat (4) @(posedge clk);
    #1 CS = 1;
  endtask
  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_oe", dout_oe, 0);
    check("rst_dout", dout, 0);
    check("rst_pulses", any, 0);
    bw(0, 8'h55);
    check("unprog_ignored", npul, 0);
    bw(3, 8'h34);
    check("cw_wr", a_cw, 3'b001);
    check("cw_data", a_cwd, 8'h34);
    check("cw_latency", lat, 3);
    check("cw_one_clk", npul, 1);
    bw(0, 8'h10);
    check("lsb0", a_lsb, 3'b001);
    check("lsb0_nomsb", a_msb, 0);
    check("lsb0_data", a_crd, 8'h10);
    check("lsb0_noload", a_ld, 0);
    bw(0, 8'h27);
    check("msb0", a_msb, 3'b001);
    check("msb0_nolsb", a_lsb, 0);
    check("msb0_load", a_ld, 3'b001);
    check("msb0_data", a_crd, 8'h27);
    bw(3, 8'h50);
    check("cw1", a_cw, 3'b010);
    bw(1, 8'haa);
    check("rw01_lsb", a_lsb, 3'b010);
    check("rw01_load", a_ld, 3'b010);
    check("rw01_nomsb", a_msb, 0);
    check("rw01_samecyc", npul, 1);
    check("rw01_data", a_crd, 8'haa);
    bw(3, 8'h00);
    check("latch1", a_lat, 3'b001);
    bw(3, 8'h00);
    check("latch_repeat", a_lat, 0);
    br(0);
    check("rd_lsb", d, 8'h34);
    check("rd_oe", oe, 1);
    br(0);
    check("rd_msb", d, 8'h12);
    bw(3, 8'h00);
    check("latch_again", a_lat, 3'b001);
    bw(0, 8'h34);
    check("mid_lsb", a_lsb, 3'b001);
    bw(3, 8'h34);
    check("mid_cw", a_cw, 3'b001);
    bw(0, 8'h77);
    check("mid_relsb", a_lsb, 3'b001);
    check("mid_noload", a_ld, 0);
    br(3);
    check("rd_ctl_oe", oe, 0);
    check("rd_ctl_dout", d, 0);
    br(1);
    check("rd_rw01", d, 8'h78);
    clr();
    @(posedge clk); #1;
    CS = 0; A = 0; din = 8'h99; WR = 0; RD = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("overlap_oe", dout_oe, 0);
    @(posedge clk); #1 WR = 1; RD = 1;
    repeat (6) @(posedge clk);
    #1 CS = 1;
    check("overlap_nocommit", npul, 0);
    bw(0, 8'h66);
    check("overlap_msb", a_msb, 3'b001);
    check("overlap_load", a_ld, 3'b001);
    bw(3, 8'h34);
    br(0);
    check("pre_rst_lsb", d, 8'h34);
    @(posedge clk); #1;
    CS = 0; A = 0; RD = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_rst_msb", dout, 8'h12);
    #1 rst = 1;
    #1;
    check("midrst_oe", dout_oe, 0);
    check("midrst_dout", dout, 0);
    check("midrst_pulses", any, 0);
    RD = 1; CS = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    bw(0, 8'h11);
    check("postrst_ignored", npul, 0);
    bw(3, 8'h34);
    br(0);
    check("postrst_rd_lsb", d, 8'h34);
    br(0);
    check("postrst_rd_msb", d, 8'h12);
    bw(3, 8'hc2);
`ifdef READBACK_EN
    check("rb_latch", a_lat, 3'b001);
    check("rb_status", a_st, 3'b001);
    ol0 = 16'hbeef;
    br(0);
    check("rb_rd_status", d, 8'h36);
    br(0);
    check("rb_rd_lsb", d, 8'hef);
    br(0);
    check("rb_rd_msb", d, 8'hbe);
`else
    check("sc3_ignored", npul, 0);
    check("sc3_nostatus", a_st, 0);
    br(0);
    check("sc3_rd_lsb", d, 8'h34);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
